// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control-bit positions, ALU codes and the opcode decoder.
package decode_pkg;

    localparam int CTRL_W = 13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int C_REG_DST    = 0;
    localparam int C_REG_WRITE  = 1;
    localparam int C_MEM_READ   = 2;
    localparam int C_MEM_WRITE  = 3;
    localparam int C_MEM_TO_REG = 4;
    localparam int C_ALU_SRC    = 5;
    localparam int C_BRANCH     = 6;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // uses_rt marks opcodes whose rt field is a source operand (matters for load-use hazards)
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [1:0]        alu;
        logic              uses_rt;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin
                d.ctrl[C_REG_DST]   = 1'b1;
                d.ctrl[C_REG_WRITE] = 1'b1;
                d.alu               = ALU_FUNCT;
                d.uses_rt           = 1'b1;
            end
            OP_LW: begin
                d.ctrl[C_REG_WRITE]  = 1'b1;
                d.ctrl[C_MEM_READ]   = 1'b1;
                d.ctrl[C_MEM_TO_REG] = 1'b1;
                d.ctrl[C_ALU_SRC]    = 1'b1;
                d.alu                = ALU_ADD;
            end
            OP_SW: begin
                d.ctrl[C_MEM_WRITE] = 1'b1;
                d.ctrl[C_ALU_SRC]   = 1'b1;
                d.alu               = ALU_ADD;
                d.uses_rt           = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl[C_BRANCH] = 1'b1;
                d.alu            = ALU_SUB;
                d.uses_rt        = 1'b1;
            end
            OP_ADDI: begin
                d.ctrl[C_REG_WRITE] = 1'b1;
                d.ctrl[C_ALU_SRC]   = 1'b1;
                d.alu               = ALU_ADD;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: two async read ports, one sync write port, entry 0 hardwired to zero.
// Build option DECODE_WB_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [REG_AW-1:0] ra);
        if (ra == '0) return '0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == ra) return wd;
`endif
        return mem[ra];
    endfunction

    assign rd1 = rd(ra1);
    assign rd2 = rd(ra2);

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake and load-use bubble insertion.
// Optional build macro DECODE_WB_BYPASS_EN (see regfile) forwards writeback data into operands.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_wreg,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        out_alu_ctrl,
    output logic [5:0]        out_funct,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rf_op1, rf_op2;
    dec_t              dec;
    logic              hazard, take;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[21 +: REG_AW];
    assign rt     = in_instr[16 +: REG_AW];
    assign rd     = in_instr[11 +: REG_AW];
    assign imm    = in_instr[15:0];
    assign dec    = decode_op(opcode);

    regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rf_op1),
        .rd2 (rf_op2),
        .we  (wb_en),
        .wa  (wb_addr),
        .wd  (wb_data)
    );

    // A load sitting in the output register blocks a consumer until the load has moved on
    assign hazard = out_valid && out_ctrl[C_MEM_READ] && out_wreg != '0 &&
                    (out_wreg == rs || (dec.uses_rt && out_wreg == rt));
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_op1      <= '0;
            out_op2      <= '0;
            out_imm      <= '0;
            out_wreg     <= '0;
            out_ctrl     <= '0;
            out_alu_ctrl <= '0;
            out_funct    <= '0;
        end else if (take) begin
            out_valid    <= 1'b1;
            out_op1      <= rf_op1;
            out_op2      <= rf_op2;
            out_imm      <= {{(DATA_W-16){imm[15]}}, imm};
            out_wreg     <= dec.ctrl[C_REG_DST] ? rd : rt;
            out_ctrl     <= dec.ctrl;
            out_alu_ctrl <= dec.alu;
            out_funct    <= in_instr[5:0];
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, hand sequences, randomized run vs. model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] out_op1, out_op2, out_imm;
    logic [4:0]  out_wreg;
    logic [12:0] out_ctrl;
    logic [1:0]  out_alu_ctrl;
    logic [5:0]  out_funct;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_wreg(out_wreg), .out_ctrl(out_ctrl), .out_alu_ctrl(out_alu_ctrl),
        .out_funct(out_funct),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_op1, m_op2, m_imm;
    logic [4:0]  m_wreg;
    logic [12:0] m_ctrl;
    logic [1:0]  m_alu;
    logic [5:0]  m_funct;
    logic        last_rdy;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] op1, op2, imm;
        logic [4:0]  wreg;
        logic [12:0] ctrl;
        logic [1:0]  alu;
        logic [5:0]  funct;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void mdec(input logic [5:0] op, output logic [12:0] c,
                                 output logic [1:0] a, output logic urt);
        case (op)
            6'h00:   begin c = 13'h003; a = 2'b10; urt = 1'b1; end
            6'h23:   begin c = 13'h036; a = 2'b00; urt = 1'b0; end
            6'h2B:   begin c = 13'h028; a = 2'b00; urt = 1'b1; end
            6'h04:   begin c = 13'h040; a = 2'b01; urt = 1'b1; end
            6'h08:   begin c = 13'h022; a = 2'b00; urt = 1'b0; end
            default: begin c = 13'h000; a = 2'b00; urt = 1'b0; end
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'h0;
        if (BYP && we && wa == r) return wd;
        return m_rf[r];
    endfunction

    task automatic mreset();
        m_valid = 1'b0;
        m_op1 = '0; m_op2 = '0; m_imm = '0; m_wreg = '0;
        m_ctrl = '0; m_alu = '0; m_funct = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [4:0]  rs, rt, rd;
        logic [12:0] c;
        logic [1:0]  a;
        logic        urt, hz, rdy;
        @(negedge clk);
        in_valid = iv; in_instr = ins; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        mdec(ins[31:26], c, a, urt);
        hz  = m_valid && m_ctrl[2] && m_wreg != 5'd0 && (m_wreg == rs || (urt && m_wreg == rt));
        rdy = (!m_valid || ordy) && !hz;
        last_rdy = in_ready;
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (iv && rdy) begin
            m_valid = 1'b1;
            m_op1   = mread(rs, we, wa, wd);
            m_op2   = mread(rt, we, wa, wd);
            m_imm   = 32'(signed'(ins[15:0]));
            m_wreg  = (ins[31:26] == 6'h00) ? rd : rt;
            m_ctrl  = c;
            m_alu   = a;
            m_funct = ins[5:0];
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        if (we && wa != 5'd0) m_rf[wa] = wd;
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("op1", out_op1, m_op1);
            chk("op2", out_op2, m_op2);
            chk("imm", out_imm, m_imm);
            chk("wreg", out_wreg, m_wreg);
            chk("ctrl", out_ctrl, m_ctrl);
            chk("alu", out_alu_ctrl, m_alu);
            chk("funct", out_funct, m_funct);
        end
    endtask

    initial begin
        vecs[0] = '{32'h00642820, 32'h5,   32'h7, 32'h00002820, 5'd5, 13'h003, 2'b10, 6'h20};
        vecs[1] = '{32'h8C22FFFC, 32'h100, 32'h0, 32'hFFFFFFFC, 5'd2, 13'h036, 2'b00, 6'h3C};
        vecs[2] = '{32'hAC640008, 32'h5,   32'h7, 32'h00000008, 5'd4, 13'h028, 2'b00, 6'h08};
        vecs[3] = '{32'h1064FFFF, 32'h5,   32'h7, 32'hFFFFFFFF, 5'd4, 13'h040, 2'b01, 6'h3F};
        vecs[4] = '{32'h20667FFF, 32'h5,   32'h0, 32'h00007FFF, 5'd6, 13'h022, 2'b00, 6'h3F};
        vecs[5] = '{32'hFC641234, 32'h5,   32'h7, 32'h00001234, 5'd4, 13'h000, 2'b00, 6'h34};

        rst = 1'b1; in_valid = 0; in_instr = 0; out_ready = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        mreset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_op1", out_op1, 32'h0);
        chk("rst_ctrl", out_ctrl, 13'h0);
        chk("rst_in_ready", in_ready, 1'b1);

        // preload r3=5, r4=7, r1=0x100
        step(0, 32'h0, 1, 1, 5'd3, 32'h5);
        step(0, 32'h0, 1, 1, 5'd4, 32'h7);
        step(0, 32'h0, 1, 1, 5'd1, 32'h100);

        for (int i = 0; i < 6; i++) begin
            step(1, vecs[i].instr, 1, 0, 5'd0, 32'h0);
            chk("vec_valid", out_valid, 1'b1);
            chk("vec_op1",   out_op1, vecs[i].op1);
            chk("vec_op2",   out_op2, vecs[i].op2);
            chk("vec_imm",   out_imm, vecs[i].imm);
            chk("vec_wreg",  out_wreg, vecs[i].wreg);
            chk("vec_ctrl",  out_ctrl, vecs[i].ctrl);
            chk("vec_alu",   out_alu_ctrl, vecs[i].alu);
            chk("vec_funct", out_funct, vecs[i].funct);
        end

        // load-use: lw r2 then add r6,r2,r3 -> one bubble
        step(1, 32'h8C22FFFC, 1, 0, 5'd0, 32'h0);
        step(1, 32'h00433020, 1, 0, 5'd0, 32'h0);
        chk("haz_in_ready", last_rdy, 1'b0);
        chk("haz_bubble", out_valid, 1'b0);
        step(1, 32'h00433020, 1, 0, 5'd0, 32'h0);
        chk("haz_in_ready2", last_rdy, 1'b1);
        chk("haz_add_valid", out_valid, 1'b1);
        chk("haz_add_wreg", out_wreg, 5'd6);
        chk("haz_add_op2", out_op2, 32'h5);

        // backpressure: add held for 3 cycles, then transfers resume
        step(1, 32'h00642820, 1, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hAC640008, 0, 0, 5'd0, 32'h0);
            chk("bp_in_ready", last_rdy, 1'b0);
            chk("bp_ctrl", out_ctrl, 13'h003);
            chk("bp_op1", out_op1, 32'h5);
        end
        step(1, 32'hAC640008, 1, 0, 5'd0, 32'h0);
        chk("bp_resume_ctrl", out_ctrl, 13'h028);
        step(1, 32'h1064FFFF, 1, 0, 5'd0, 32'h0);
        chk("bp_resume2_ctrl", out_ctrl, 13'h040);

        // same-cycle writeback of r3 while add reads r3
        step(1, 32'h00642820, 1, 1, 5'd3, 32'h99);
        chk("wb_same_cycle_op1", out_op1, BYP ? 32'h99 : 32'h5);
        step(1, 32'h00642820, 1, 0, 5'd0, 32'h0);
        chk("wb_next_cycle_op1", out_op1, 32'h99);

        // r0 ignores writes
        step(0, 32'h0, 1, 1, 5'd0, 32'hFF);
        step(1, 32'h00042820, 1, 0, 5'd0, 32'h0);
        chk("r0_op1", out_op1, 32'h0);

        // asynchronous reset mid-stream
        step(1, 32'h00642820, 1, 0, 5'd0, 32'h0);
        @(negedge clk);
        in_valid = 1; in_instr = 32'h00642820; out_ready = 0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_op1", out_op1, 32'h0);
        mreset();
        @(negedge clk); rst = 1'b0;
        step(1, 32'h00642820, 1, 0, 5'd0, 32'h0);
        chk("post_rst_r3", out_op1, 32'h0);

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [31:0] ins;
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
            step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
